// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//
// Write-side counterpart of the instruction ROM. Receives a length-prefixed
// stream of DW-bit machine-code words over a valid/ready handshake and writes
// each word into the instruction memory write port at consecutive addresses
// starting from 0. Completion is signalled on Done. The core's fetch path uses
// the memory read port and is not touched here.
//
// Stream format (one word per accepted transfer):
//   word 0      : length low bits  (Lo)
//   word 1      : length high bits (Hi);  N = {Hi,Lo}[IW-1:0]
//   words 2..   : N payload words, written to addresses 0..N-1
//   last word   : checksum (only when INST_LOADER_CHECKSUM_EN is defined)
//
// Build option:
//   INST_LOADER_CHECKSUM_EN  When defined, a trailing checksum word is
//                            expected after the payload. It is compared with
//                            the XOR of all payload words, and Err reports a
//                            mismatch while Done=1. When undefined there is
//                            no checksum word and Err is tied to 0.
//
// Parameters:
//   IW  instruction address width (memory depth 2**IW)
//   DW  machine-code word width
//
// Ports:
//   Clk      in   rising-edge clock
//   Rst_n    in   asynchronous active-low reset; aborts a load immediately
//   Start    in   one-cycle pulse; starts a load from IDLE or DONE
//   InData   in   stream word
//   InValid  in   InData valid
//   InReady  out  loader accepts a word this cycle (decoded from state)
//   WrEn     out  memory write strobe (registered)
//   WrAddr   out  memory write address (registered)
//   WrData   out  memory write data (registered)
//   Busy     out  load in progress
//   Done     out  load finished; held until the next Start or reset
//   Err      out  checksum mismatch; meaningful while Done=1
// -----------------------------------------------------------------------------
module inst_loader #(
  parameter int IW = 13,
  parameter int DW = 9
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Start,
  input  logic [DW-1:0] InData,
  input  logic          InValid,
  output logic          InReady,
  output logic          WrEn,
  output logic [IW-1:0] WrAddr,
  output logic [DW-1:0] WrData,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  // Explicit codes keep the encoding stable whether or not S_CHK exists.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_LOAD = 3'd3,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CHK  = 3'd4,
`endif
    S_DONE = 3'd5
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_len_lo;     // Lo header word, held until Hi arrives
  logic [IW-1:0] r_remaining;  // payload words still to be accepted
  logic [IW-1:0] r_addr;       // address for the next payload word
  logic          r_wr_en;
  logic [IW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic          r_busy;
  logic          r_done;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [DW-1:0] r_csum;       // running XOR of payload words
  logic          r_err;
`endif

  logic          w_accept;
  logic [IW-1:0] w_len;

  // NOTE: every signal written in always_comb gets a default first, so no
  // state/branch combination can leave it unassigned and infer a latch.
  always_comb begin
    InReady = 1'b0;
    case (r_state)
      S_HDR0, S_HDR1, S_LOAD: InReady = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHK:                  InReady = 1'b1;
`endif
      default:                InReady = 1'b0;
    endcase
  end

  assign w_accept = InValid && InReady;

  // Length is {Hi,Lo} truncated to the address width, so at most 2**IW-1
  // words are loaded and the write address can never wrap.
  assign w_len = IW'({InData, r_len_lo});

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and the block order does not matter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_len_lo    <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      r_csum      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse per accepted payload word.
      r_wr_en <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state <= S_HDR0;
            r_busy  <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end

        S_HDR0: begin
          if (w_accept) begin
            r_len_lo <= InData;
            r_state  <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (w_accept) begin
            r_addr <= '0;
            if (w_len == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else begin
              r_remaining <= w_len;
              r_state     <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= InData;
            r_addr    <= r_addr + IW'(1);
`ifdef INST_LOADER_CHECKSUM_EN
            r_csum    <= r_csum ^ InData;
`endif
            if (r_remaining == IW'(1)) begin
`ifdef INST_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else begin
              r_remaining <= r_remaining - IW'(1);
            end
          end
        end

`ifdef INST_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) begin
            r_err   <= (InData != r_csum);
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`endif

        S_DONE: begin
          // Restart clears the completion flags on the same edge.
          if (Start) begin
            r_state <= S_HDR0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            r_csum  <= '0;
            r_err   <= 1'b0;
`endif
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign WrEn   = r_wr_en;
  assign WrAddr = r_wr_addr;
  assign WrData = r_wr_data;
  assign Busy   = r_busy;
  assign Done   = r_done;
`ifdef INST_LOADER_CHECKSUM_EN
  assign Err    = r_err;
`else
  assign Err    = 1'b0;
`endif

endmodule
